gb_joypad: RTL and testbench
============================

# gb_joypad

Converts the debounced SNES controller state into the Game Boy P1/JOYP register (0xFF00) and generates the joypad interrupt request. Sits directly downstream of `snes_controller`: consumes its `snes_buttons` vector in the `cpu_clock` domain and presents the CPU-side register read data, select-bit write port and interrupt pulse. One `gb_debounce` instance per Game Boy button removes glitches before the register logic sees them.

## Interface

**Parameters**
- `DEBOUNCE_CYCLES`, default 4096: consecutive cycles a raw button level must differ from the stable level before the stable level changes. Must be ≥ 1. 4096 is about 1 ms at the ~4 MHz `cpu_clock`.

**Ports**
- `clock`  in  1  `cpu_clock`; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `snes_buttons`  in  16  from `snes_controller`, 1 = pressed.
  - Bit map: 0 B, 1 Y, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right, 8 A, 9 X, 10 L, 11 R, 15:12 unused.
- `p1_wr`  in  1  one-cycle write strobe for 0xFF00.
- `p1_wdata`  in  8  write data; only bits 5:4 are used.
- `p1_rdata`  out  8  current P1 read value.
- `irq_joypad`  out  1  one-cycle interrupt request pulse (IF bit 4).
- `buttons_dbg`  out  8  debounced GB buttons, 1 = pressed.
  - Order: {Start, Select, B, A, Down, Up, Left, Right}.

## Operation

**Button mapping (raw, before debounce)**
- GB A = SNES A | X; GB B = SNES B | Y; Select, Start and D-pad map directly.
- L, R and bits 15:12 are ignored.
- Opposing directions are passed through unmodified.

**Debounce (per button)**
- Each button keeps a `stable` bit and a counter of width $clog2(DEBOUNCE_CYCLES+1).
- If raw == stable, the counter clears.
- Otherwise the counter increments. On the edge where the counter equals DEBOUNCE_CYCLES−1, `stable` takes the raw value and the counter clears.
- A raw pulse shorter than DEBOUNCE_CYCLES cycles never reaches `stable`.

**Select register**
- `sel[1:0]` holds P15 (bit 5) and P14 (bit 4); reset value 2'b11.
- On `p1_wr`, `sel <= p1_wdata[5:4]`. Other written bits are discarded.

**Read value**
- `p1_rdata = {2'b11, sel, ~nib}`.
- `nib = (P14==0 ? dir : 0) | (P15==0 ? act : 0)`.
  - `dir` = {Down, Up, Left, Right}.
  - `act` = {Start, Select, B, A}.
- Both groups selected: the groups are ORed (wired-AND of the active-low lines).
- Neither group selected: low nibble reads 0xF.

**Interrupt**
- A registered copy `nib_q` of the active-low nibble is kept.
- `irq_joypad <= |(nib_q & ~nib_now)`, i.e. any P10–P13 line falling high→low.
- Falling edges caused by a select change count as well as those caused by a button press.
- Releases (low→high) never raise the interrupt.

## Timing

**Reset values**
- `sel` = 2'b11; all `stable` bits = 0; counters = 0; `nib_q` = 4'hF.
- Outputs: `p1_rdata` = 8'hFF, `irq_joypad` = 0, `buttons_dbg` = 0.
- `rst` has priority over `p1_wr`.
- Reset mid-debounce discards the partial count. The button is then treated as released until it has been held a full DEBOUNCE_CYCLES after reset.

**Latency**
- Raw change held from edge N: `stable` updates at edge N+DEBOUNCE_CYCLES−1.
- `p1_rdata` is combinational from registers, so it reflects the change in the same cycle `stable` updates.
- `irq_joypad` is high for exactly the one following cycle.

**Writes**
- A `p1_wr` at edge N changes `p1_rdata` after edge N.
- Any resulting interrupt pulses after edge N+1.

**Boundary cases**
- Simultaneous press and select change in one cycle produce a single pulse, because the interrupt is computed on the combined nibble.
- A held button never re-pulses.
- With DEBOUNCE_CYCLES = 1, `stable` follows raw with one cycle of delay.

## Structure

- Shared package `gb_pkg` holds:
  - the SNES bit-index constants (SNES_B … SNES_R);
  - the GB button index constants;
  - the P1 address constant 16'hFF00;
  - the IF bit constant IRQ_JOYPAD_BIT = 4.
- Sub-module `gb_debounce` (single-bit, parameter DEBOUNCE_CYCLES): ports `clock`, `rst`, `raw`, `stable`. `gb_joypad` instantiates it 8 times.
- Address decoding of 0xFF00 is outside this block. The bus provides `p1_wr` already qualified.

## Test plan

All scenarios use DEBOUNCE_CYCLES = 4.

1. Reset, no buttons -> `p1_rdata` = 8'hFF, `irq_joypad` = 0, `buttons_dbg` = 8'h00.
2. Write 8'h20, then hold Right (bit 7) 4 cycles -> `p1_rdata` = 8'hEE and `irq_joypad` high for exactly 1 cycle. Release Right -> 8'hEF, no pulse.
3. Write 8'h20, Right high for 3 cycles then low -> `p1_rdata` stays 8'hEF, no pulse.
4. Write 8'h00, hold SNES X and Up -> `p1_rdata` = 8'hCA (X maps to A), one pulse.
5. Write 8'h30 and hold A until debounced -> `p1_rdata` = 8'hFF, no pulse. Then write 8'h10 -> 8'hDE, one pulse two edges after the write.
6. Hold B for 2 cycles, assert `rst`, keep B held -> after reset `buttons_dbg` = 0 and B appears exactly 4 cycles after `rst` deasserts.

Source files
------------

// File: rtl/gb_joypad_pkg.sv
// Shared constants for the Game Boy joypad block: SNES/GB bit indices,
// the P1 register address and the IF bit used for the joypad interrupt.
package gb_pkg;

    localparam int unsigned SNES_B      = 0;
    localparam int unsigned SNES_Y      = 1;
    localparam int unsigned SNES_SELECT = 2;
    localparam int unsigned SNES_START  = 3;
    localparam int unsigned SNES_UP     = 4;
    localparam int unsigned SNES_DOWN   = 5;
    localparam int unsigned SNES_LEFT   = 6;
    localparam int unsigned SNES_RIGHT  = 7;
    localparam int unsigned SNES_A      = 8;
    localparam int unsigned SNES_X      = 9;
    localparam int unsigned SNES_L      = 10;
    localparam int unsigned SNES_R      = 11;

    // Debounced button vector order: {Start, Select, B, A, Down, Up, Left, Right}
    localparam int unsigned GB_RIGHT  = 0;
    localparam int unsigned GB_LEFT   = 1;
    localparam int unsigned GB_UP     = 2;
    localparam int unsigned GB_DOWN   = 3;
    localparam int unsigned GB_A      = 4;
    localparam int unsigned GB_B      = 5;
    localparam int unsigned GB_SELECT = 6;
    localparam int unsigned GB_START  = 7;

    localparam logic [15:0] P1_ADDR        = 16'hFF00;
    localparam int unsigned IRQ_JOYPAD_BIT = 4;

    typedef struct packed {
        logic p15;
        logic p14;
    } p1_sel_t;

endpackage

// File: rtl/gb_joypad_if.sv
// CPU-side P1 register bundle: qualified write strobe/data, read data and IRQ pulse.
interface gb_joypad_if;

    logic       p1_wr;
    logic [7:0] p1_wdata;
    logic [7:0] p1_rdata;
    logic       irq_joypad;

    modport master (
        output p1_wr,
        output p1_wdata,
        input  p1_rdata,
        input  irq_joypad
    );

    modport slave (
        input  p1_wr,
        input  p1_wdata,
        output p1_rdata,
        output irq_joypad
    );

endinterface

// File: rtl/gb_joypad_debounce.sv
// Single-bit debouncer: the stable level follows raw only after raw has
// differed from it for DEBOUNCE_CYCLES consecutive cycles.
module gb_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4096
) (
    input  logic clock,
    input  logic rst,
    input  logic raw,
    output logic stable
);

    localparam int unsigned    CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (raw != stable_q) begin
            if (cnt_q == LAST) begin
                stable_d = raw;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/gb_joypad.sv
// Game Boy P1/JOYP register built from the SNES controller state: per-button
// debounce, select-line write port, active-low read nibble and joypad IRQ.
module gb_joypad
    import gb_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4096
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [15:0] snes_buttons,
    input  logic        p1_wr,
    input  logic [7:0]  p1_wdata,
    output logic [7:0]  p1_rdata,
    output logic        irq_joypad,
    output logic [7:0]  buttons_dbg
);

    logic [7:0] raw;
    logic [7:0] stable;
    p1_sel_t    sel_q, sel_d;
    logic [3:0] nib_q;
    logic [3:0] nib_now;
    logic       irq_q, irq_d;

    // L, R and the spare high bits carry no Game Boy meaning
    logic unused_bits;
    assign unused_bits = ^{snes_buttons[15:12], snes_buttons[SNES_R], snes_buttons[SNES_L],
                           p1_wdata[7:6], p1_wdata[3:0]};

    always_comb begin
        raw            = '0;
        raw[GB_RIGHT]  = snes_buttons[SNES_RIGHT];
        raw[GB_LEFT]   = snes_buttons[SNES_LEFT];
        raw[GB_UP]     = snes_buttons[SNES_UP];
        raw[GB_DOWN]   = snes_buttons[SNES_DOWN];
        raw[GB_A]      = snes_buttons[SNES_A] | snes_buttons[SNES_X];
        raw[GB_B]      = snes_buttons[SNES_B] | snes_buttons[SNES_Y];
        raw[GB_SELECT] = snes_buttons[SNES_SELECT];
        raw[GB_START]  = snes_buttons[SNES_START];
    end

    for (genvar i = 0; i < 8; i++) begin : g_db
        gb_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_db (
            .clock  (clock),
            .rst    (rst),
            .raw    (raw[i]),
            .stable (stable[i])
        );
    end

    // Both groups selected OR together, modelling the wired-AND of the active-low lines
    always_comb begin
        logic [3:0] nib;
        nib      = '0;
        if (!sel_q.p14) nib = nib | stable[3:0];
        if (!sel_q.p15) nib = nib | stable[7:4];
        nib_now  = ~nib;

        sel_d = sel_q;
        if (p1_wr) sel_d = p1_sel_t'(p1_wdata[5:4]);

        irq_d = |(nib_q & ~nib_now);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            sel_q <= 2'b11;
            nib_q <= 4'hF;
            irq_q <= 1'b0;
        end else begin
            sel_q <= sel_d;
            nib_q <= nib_now;
            irq_q <= irq_d;
        end
    end

    assign p1_rdata    = {2'b11, sel_q, nib_now};
    assign irq_joypad  = irq_q;
    assign buttons_dbg = stable;

endmodule

// File: tb/tb_gb_joypad.sv
// Scoreboard bench for gb_joypad with DEBOUNCE_CYCLES = 4: stimulus queues the
// expected read-value changes and IRQ pulses with their cycle, a monitor matches them.
module tb_gb_joypad;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] snes;
    logic [7:0]  dbg;

    gb_joypad_if bus ();

    gb_joypad #(
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clock        (clk),
        .rst          (rst),
        .snes_buttons (snes),
        .p1_wr        (bus.p1_wr),
        .p1_wdata     (bus.p1_wdata),
        .p1_rdata     (bus.p1_rdata),
        .irq_joypad   (bus.irq_joypad),
        .buttons_dbg  (dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          is_irq;
        logic [7:0]  val;
        int unsigned at;
    } ev_t;

    ev_t         sb[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic [7:0]  prev_rd;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_rd(input string name, input logic [7:0] v, input int unsigned dt);
        ev_t e;
        e.name = name; e.is_irq = 1'b0; e.val = v; e.at = cyc + dt;
        sb.push_back(e);
    endtask

    task automatic exp_irq(input string name, input int unsigned dt);
        ev_t e;
        e.name = name; e.is_irq = 1'b1; e.val = 8'h00; e.at = cyc + dt;
        sb.push_back(e);
    endtask

    task automatic wr_p1(input logic [7:0] v);
        bus.p1_wr    = 1'b1;
        bus.p1_wdata = v;
        tick(1);
        bus.p1_wr    = 1'b0;
        bus.p1_wdata = 8'h00;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, req, cyc);
        end
    endtask

    task automatic got(input bit is_irq, input logic [7:0] v);
        ev_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event actual irq=%0d val=%h cyc=%0d required none",
                     is_irq, v, cyc);
        end else begin
            e = sb.pop_front();
            if (e.is_irq != is_irq || (!is_irq && e.val !== v) || e.at != cyc) begin
                errors++;
                $display("FAIL %s actual irq=%0d val=%h cyc=%0d required irq=%0d val=%h cyc=%0d",
                         e.name, is_irq, v, cyc, e.is_irq, e.val, e.at);
            end
        end
    endtask

    // Monitor: every read-value change and every IRQ cycle is an event to match
    always @(negedge clk) begin
        if (!mon_en) begin
            prev_rd = bus.p1_rdata;
        end else begin
            if (bus.p1_rdata !== prev_rd) begin
                got(1'b0, bus.p1_rdata);
                prev_rd = bus.p1_rdata;
            end
            if (bus.irq_joypad !== 1'b0) got(1'b1, 8'h00);
        end
    end

    initial begin
        rst          = 1'b1;
        snes         = 16'h0000;
        bus.p1_wr    = 1'b0;
        bus.p1_wdata = 8'h00;
        tick(2);
        rst = 1'b0;

        chk("reset_rdata", bus.p1_rdata, 8'hFF);
        chk("reset_irq", {7'd0, bus.irq_joypad}, 8'h00);
        chk("reset_dbg", dbg, 8'h00);
        mon_en = 1'b1;
        tick(1);

        // Direction group, Right press and release
        exp_rd("t2_sel", 8'hEF, 1);
        wr_p1(8'h20);
        snes[7] = 1'b1;
        exp_rd("t2_press", 8'hEE, 4);
        exp_irq("t2_irq", 5);
        tick(8);
        chk("t2_dbg", dbg, 8'h01);
        chk("t2_rdata", bus.p1_rdata, 8'hEE);
        snes = 16'h0000;
        exp_rd("t2_release", 8'hEF, 4);
        tick(8);

        // Glitch shorter than the debounce window
        wr_p1(8'h20);
        snes[7] = 1'b1;
        tick(3);
        snes = 16'h0000;
        tick(8);
        chk("t3_rdata", bus.p1_rdata, 8'hEF);
        chk("t3_dbg", dbg, 8'h00);

        // Both groups, X maps to A, plus Up
        exp_rd("t4_sel", 8'hCF, 1);
        wr_p1(8'h00);
        snes = 16'h0210;
        exp_rd("t4_press", 8'hCA, 4);
        exp_irq("t4_irq", 5);
        tick(8);
        chk("t4_dbg", dbg, 8'h14);
        snes = 16'h0000;
        exp_rd("t4_release", 8'hCF, 4);
        tick(8);

        // Deselected press is invisible; selecting it later raises the IRQ
        exp_rd("t5_sel", 8'hFF, 1);
        wr_p1(8'h30);
        snes = 16'h0100;
        tick(8);
        chk("t5_dbg", dbg, 8'h10);
        chk("t5_rdata", bus.p1_rdata, 8'hFF);
        exp_rd("t5_wr", 8'hDE, 1);
        exp_irq("t5_irq", 2);
        wr_p1(8'h10);
        tick(4);
        snes = 16'h0000;
        exp_rd("t5_release", 8'hDF, 4);
        tick(8);

        // Reset mid-debounce discards the partial count
        snes = 16'h0001;
        tick(2);
        rst = 1'b1;
        exp_rd("t6_reset", 8'hFF, 1);
        tick(1);
        rst = 1'b0;
        chk("t6_dbg_after_rst", dbg, 8'h00);
        tick(3);
        chk("t6_dbg_3cyc", dbg, 8'h00);
        tick(1);
        chk("t6_dbg_4cyc", dbg, 8'h20);
        exp_rd("t6_wr", 8'hDD, 1);
        exp_irq("t6_irq", 2);
        wr_p1(8'h10);
        tick(4);
        snes = 16'h0000;
        exp_rd("t6_release", 8'hDF, 4);
        tick(10);

        chk("sb_drained", 8'(sb.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
